// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: datapath widths, ALU op
// encodings and the arbiter state machine encoding.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;

   // ALU operation codes; codes 10..15 are undefined and produce zero
   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLT  = 4'd2,
      ALU_SLTU = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_AND  = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9
   } alu_op_e;

   // Arbiter FSM: accept a request, compute, hold the response
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit integer ALU shared by all requesters.
module alu
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_b,
   input  logic [OP_W-1:0]   op,
   output logic [DATA_W-1:0] result
);

   logic signed [DATA_W-1:0] a_s;
   logic signed [DATA_W-1:0] b_s;
   logic        [4:0]        shamt;

   assign a_s   = operand_a;
   assign b_s   = operand_b;
   assign shamt = operand_b[4:0];

   // Decode the op code; anything outside the defined set yields zero
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = operand_a + operand_b;
         ALU_SUB:  result = operand_a - operand_b;
         ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
         ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (operand_a < operand_b)};
         ALU_XOR:  result = operand_a ^ operand_b;
         ALU_OR:   result = operand_a | operand_b;
         ALU_AND:  result = operand_a & operand_b;
         ALU_SLL:  result = operand_a << shamt;
         ALU_SRL:  result = operand_a >> shamt;
         ALU_SRA:  result = $unsigned(a_s >>> shamt);
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one ALU.
// One operation is in flight at a time: accept (IDLE), compute (EXEC),
// then hold the result (RESP) until the owning requester takes it.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N_REQ = 2
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [N_REQ-1:0]        i_req_valid,
   output logic [N_REQ-1:0]        o_req_ready,
   input  logic [N_REQ*DATA_W-1:0] i_req_operand_a,
   input  logic [N_REQ*DATA_W-1:0] i_req_operand_b,
   input  logic [N_REQ*OP_W-1:0]   i_req_alu_op,
   output logic [N_REQ-1:0]        o_rsp_valid,
   input  logic [N_REQ-1:0]        i_rsp_ready,
   output logic [DATA_W-1:0]       o_rsp_data,
   output logic                    o_busy
);

   localparam int IDX_W = $clog2(N_REQ);

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // First valid requester at or after ptr, wrapping modulo N_REQ
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] valid,
                                     input logic [IDX_W-1:0] ptr);
      pick_t            p;
      int               j;
      logic [IDX_W-1:0] jj;
      p = '0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= N_REQ) j = j - N_REQ;
         jj = j[IDX_W-1:0];
         if (!p.found && valid[jj]) begin
            p.found = 1'b1;
            p.idx   = jj;
         end
      end
      return p;
   endfunction

   // Pointer to the requester after idx, wrapping modulo N_REQ
   function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
      int n;
      n = int'(idx) + 1;
      if (n >= N_REQ) n = 0;
      return n[IDX_W-1:0];
   endfunction

   arb_state_e        state;
   arb_state_e        state_nxt;
   logic [IDX_W-1:0]  rr_ptr;
   pick_t             pick;
   logic              hs;
   logic              rsp_done;
   logic [N_REQ-1:0]  grant_vec;
   logic [N_REQ-1:0]  rsp_vec;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;
   logic [OP_W-1:0]   sel_op;

   // Stage p0: operands captured at the handshake
   logic [DATA_W-1:0] op_a_p0;
   logic [DATA_W-1:0] op_b_p0;
   logic [OP_W-1:0]   op_p0;
   logic [IDX_W-1:0]  gnt_p0;

   // Stage p1: ALU result held for the response
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] result_p1;

   assign pick     = rr_pick(i_req_valid, rr_ptr);
   assign rsp_done = |(rsp_vec & i_rsp_ready);

   // Steer the winner's request fields and build one-hot grant/response vectors
   always_comb begin
      grant_vec = '0;
      rsp_vec   = '0;
      sel_a     = '0;
      sel_b     = '0;
      sel_op    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick.idx == k[IDX_W-1:0]) begin
            grant_vec[k] = 1'b1;
            sel_a        = i_req_operand_a[k*DATA_W +: DATA_W];
            sel_b        = i_req_operand_b[k*DATA_W +: DATA_W];
            sel_op       = i_req_alu_op[k*OP_W +: OP_W];
         end
         if (gnt_p0 == k[IDX_W-1:0]) begin
            rsp_vec[k] = 1'b1;
         end
      end
   end

   // Next-state and handshake outputs; everything forced quiet while in reset
   always_comb begin
      state_nxt   = state;
      hs          = 1'b0;
      o_req_ready = '0;
      o_rsp_valid = '0;
      o_rsp_data  = '0;
      o_busy      = 1'b0;
      if (!i_reset) begin
         o_busy = (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (pick.found) begin
                  hs          = 1'b1;
                  o_req_ready = grant_vec;
                  state_nxt   = ST_EXEC;
               end
            end
            ST_EXEC: begin
               state_nxt = ST_RESP;
            end
            ST_RESP: begin
               o_rsp_valid = rsp_vec;
               o_rsp_data  = result_p1;
               if (rsp_done) state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Capture the accepted request, advance the round-robin pointer, latch the result
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rr_ptr    <= '0;
         op_a_p0   <= '0;
         op_b_p0   <= '0;
         op_p0     <= '0;
         gnt_p0    <= '0;
         result_p1 <= '0;
      end else begin
         // p0 boundary: request fields registered on handshake
         if (hs) begin
            op_a_p0 <= sel_a;
            op_b_p0 <= sel_b;
            op_p0   <= sel_op;
            gnt_p0  <= pick.idx;
            rr_ptr  <= rr_next(pick.idx);
         end
         // p1 boundary: ALU output registered during EXEC
         if (state == ST_EXEC) begin
            result_p1 <= alu_res;
         end
      end
   end

   alu u_alu (
      .operand_a (op_a_p0),
      .operand_b (op_b_p0),
      .op        (op_p0),
      .result    (alu_res)
   );

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by
// randomized traffic, with a reference model and response scoreboard.
module tb_alu_arbiter;

   localparam int N = 2;

   typedef struct {
      int          idx;
      logic [31:0] data;
   } rsp_t;

   logic            i_clk;
   logic            i_reset;
   logic [N-1:0]    i_req_valid;
   logic [N-1:0]    o_req_ready;
   logic [N*32-1:0] i_req_operand_a;
   logic [N*32-1:0] i_req_operand_b;
   logic [N*4-1:0]  i_req_alu_op;
   logic [N-1:0]    o_rsp_valid;
   logic [N-1:0]    i_rsp_ready;
   logic [31:0]     o_rsp_data;
   logic            o_busy;

   logic            drv_v  [N];
   logic [31:0]     drv_a  [N];
   logic [31:0]     drv_b  [N];
   logic [3:0]      drv_op [N];

   int              n_checks = 0;
   int              n_errors = 0;
   int              cycle    = 0;
   rsp_t            exp_q[$];
   rsp_t            rsp_log[$];
   logic [N-1:0]    hs_last;

   bit              m_busy;
   int              m_age;
   int              m_g;
   int              m_ptr;

   alu_arbiter #(.N_REQ(N)) dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_req_valid     (i_req_valid),
      .o_req_ready     (o_req_ready),
      .i_req_operand_a (i_req_operand_a),
      .i_req_operand_b (i_req_operand_b),
      .i_req_alu_op    (i_req_alu_op),
      .o_rsp_valid     (o_rsp_valid),
      .i_rsp_ready     (i_rsp_ready),
      .o_rsp_data      (o_rsp_data),
      .o_busy          (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cycle <= cycle + 1;

   // Pack per-requester driver fields onto the DUT buses
   always_comb begin
      for (int k = 0; k < N; k++) begin
         i_req_valid[k]             = drv_v[k];
         i_req_operand_a[k*32 +: 32] = drv_a[k];
         i_req_operand_b[k*32 +: 32] = drv_b[k];
         i_req_alu_op[k*4 +: 4]      = drv_op[k];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   function automatic bit bit_of(input logic [N-1:0] v, input int k);
      logic [N-1:0] t;
      t = v >> k;
      return t[0];
   endfunction

   function automatic int idx_of(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (bit_of(v, i)) return i;
      return -1;
   endfunction

   // Reference ALU written from the op definitions
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned s;
      s = b % 32;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'd3: return (a < b) ? 32'd1 : 32'd0;
         4'd4: return a ^ b;
         4'd5: return a | b;
         4'd6: return a & b;
         4'd7: return a << s;
         4'd8: return a >> s;
         4'd9: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   // Reference model: predicts grants, busy and response timing; pushes expected results
   initial begin : model
      logic [N-1:0] e_ready;
      logic [N-1:0] e_rvalid;
      logic         e_busy;
      bit           found;
      int           g;
      m_busy = 0; m_age = 0; m_g = 0; m_ptr = 0;
      forever begin
         @(negedge i_clk);
         e_ready = '0; e_rvalid = '0; e_busy = 1'b0; found = 0; g = 0;
         if (!i_reset) begin
            if (!m_busy) begin
               for (int i = 0; i < N; i++) begin
                  int j;
                  j = (m_ptr + i) % N;
                  if (!found && drv_v[j]) begin found = 1; g = j; end
               end
               if (found) e_ready = N'(1) << g;
            end else begin
               e_busy = 1'b1;
               if (m_age >= 2) e_rvalid = N'(1) << m_g;
            end
         end
         chk("req_ready", 32'(o_req_ready), 32'(e_ready));
         chk("rsp_valid", 32'(o_rsp_valid), 32'(e_rvalid));
         chk("busy", 32'(o_busy), 32'(e_busy));
         if (i_reset) begin
            m_busy = 0; m_age = 0; m_ptr = 0;
            exp_q.delete();
         end else if (!m_busy) begin
            if (found) begin
               exp_q.push_back('{g, ref_alu(drv_op[g], drv_a[g], drv_b[g])});
               m_g = g; m_ptr = (g + 1) % N; m_busy = 1; m_age = 1;
            end
         end else if (m_age >= 2) begin
            if (bit_of(i_rsp_ready, m_g)) m_busy = 0;
         end else begin
            m_age++;
         end
      end
   end

   // Monitor: compares each presented response against the scoreboard head
   initial begin : monitor
      forever begin
         @(negedge i_clk);
         if (o_rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 32'(o_rsp_valid), 32'h0);
            end else begin
               chk("rsp_data", o_rsp_data, exp_q[0].data);
               chk("rsp_idx", 32'(o_rsp_valid), 32'(N'(1) << exp_q[0].idx));
               if ((o_rsp_valid & i_rsp_ready) != '0) begin
                  rsp_log.push_back('{idx_of(o_rsp_valid), o_rsp_data});
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            chk("rsp_data_idle", o_rsp_data, 32'h0);
         end
      end
   end

   initial begin : watchdog
      #(2_000_000);
      $display("FAIL watchdog: simulation did not finish, got cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge i_clk);
      hs_last = i_req_valid & o_req_ready;
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      drv_v[k] = v; drv_a[k] = a; drv_b[k] = b; drv_op[k] = op;
   endtask

   task automatic wait_grant(input int k, input string name);
      bit got;
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         step();
         if (bit_of(hs_last, k)) got = 1;
      end
      if (!got) chk({name, "_grant_timeout"}, 32'(hs_last), 32'(N'(1) << k));
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while ((m_busy || exp_q.size() != 0) && c < 60) begin
         step();
         c++;
      end
      if (c >= 60) chk("idle_timeout", 32'(exp_q.size()), 32'h0);
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
   endtask

   task automatic run_one(input int k, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input string name, input logic [31:0] exp);
      int n0;
      n0 = rsp_log.size();
      set_req(k, 1'b1, a, b, op);
      wait_grant(k, name);
      set_req(k, 1'b0, 32'h0, 32'h0, 4'h0);
      wait_idle();
      if (rsp_log.size() == n0 + 1) begin
         chk({name, "_data"}, rsp_log[n0].data, exp);
         chk({name, "_idx"}, 32'(rsp_log[n0].idx), 32'(k));
      end else begin
         chk({name, "_count"}, 32'(rsp_log.size() - n0), 32'd1);
      end
   endtask

   initial begin : stimulus
      int n0;
      logic [N-1:0] r;
      for (int k = 0; k < N; k++) set_req(k, 1'b0, 32'h0, 32'h0, 4'h0);
      i_rsp_ready = '1;
      i_reset     = 1'b1;
      hs_last     = '0;

      // Reset: outputs quiet even with requests pending
      step();
      set_req(0, 1'b1, 32'd1, 32'd2, 4'd0);
      set_req(1, 1'b1, 32'd3, 32'd4, 4'd0);
      step();
      chk("rst_req_ready", 32'(o_req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
      chk("rst_rsp_data", o_rsp_data, 32'h0);
      chk("rst_busy", 32'(o_busy), 32'h0);
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      i_reset = 1'b0;
      step();

      // Single request: ADD 5+7, response two cycles after the handshake
      set_req(0, 1'b1, 32'd5, 32'd7, 4'd0);
      wait_grant(0, "add");
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      step();
      chk("add_rsp_valid", 32'(o_rsp_valid), 32'h1);
      chk("add_rsp_data", o_rsp_data, 32'd12);
      wait_idle();

      // Contention from reset: k0 first, then alternating
      do_reset();
      n0 = rsp_log.size();
      set_req(0, 1'b1, 32'd10, 32'd3, 4'd1);
      set_req(1, 1'b1, 32'h8000_0000, 32'd4, 4'd9);
      i_rsp_ready = '1;
      for (int c = 0; c < 12; c++) step();
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      wait_idle();
      chk("cont_count", 32'(rsp_log.size() - n0), 32'd4);
      if (rsp_log.size() >= n0 + 4) begin
         for (int e = 0; e < 4; e++) begin
            chk("cont_idx", 32'(rsp_log[n0+e].idx), 32'(e % 2));
            chk("cont_data", rsp_log[n0+e].data, (e % 2 == 0) ? 32'd7 : 32'hF800_0000);
         end
      end

      // Response backpressure on k1 with k0 waiting
      i_rsp_ready = 2'b01;
      set_req(1, 1'b1, 32'hA5A5_A5A5, 32'hFFFF_0000, 4'd4);
      wait_grant(1, "bp");
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(0, 1'b1, 32'd1, 32'd2, 4'd0);
      step();
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 32'(o_rsp_valid), 32'h2);
         chk("bp_data", o_rsp_data, 32'h5A5A_A5A5);
         chk("bp_ready", 32'(o_req_ready), 32'h0);
         step();
      end
      i_rsp_ready = 2'b11;
      wait_grant(0, "bp_k0");
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      wait_idle();

      // Signed/unsigned compare and undefined op
      run_one(0, 32'hFFFF_FFFF, 32'd1, 4'd2, "slt", 32'd1);
      run_one(0, 32'hFFFF_FFFF, 32'd1, 4'd3, "sltu", 32'd0);
      run_one(1, 32'h1234_5678, 32'h0F0F_0F0F, 4'hF, "op_undef", 32'd0);

      // Reset during EXEC discards the transaction
      n0 = rsp_log.size();
      set_req(1, 1'b1, 32'd100, 32'd200, 4'd0);
      wait_grant(1, "rexec");
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      do_reset();
      chk("rexec_busy", 32'(o_busy), 32'h0);
      chk("rexec_rsp_valid", 32'(o_rsp_valid), 32'h0);
      set_req(0, 1'b1, 32'd9, 32'd4, 4'd1);
      set_req(1, 1'b1, 32'd8, 32'd8, 4'd0);
      step();
      chk("rexec_fresh_grant", 32'(hs_last), 32'h1);
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      wait_idle();
      chk("rexec_log", 32'(rsp_log.size() - n0), 32'd1);
      if (rsp_log.size() == n0 + 1) chk("rexec_data", rsp_log[n0].data, 32'd5);

      // Withdrawn request while busy
      n0 = rsp_log.size();
      set_req(0, 1'b1, 32'd3, 32'd3, 4'd6);
      wait_grant(0, "wd");
      set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_req(1, 1'b1, 32'd1, 32'd1, 4'd0);
      chk("wd_ready", 32'(o_req_ready), 32'h0);
      step();
      set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
      wait_idle();
      chk("wd_log", 32'(rsp_log.size() - n0), 32'd1);
      if (rsp_log.size() == n0 + 1) chk("wd_idx", 32'(rsp_log[n0].idx), 32'd0);

      // Randomized traffic with withdrawals, backpressure and rare resets
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < N; k++) begin
            if (drv_v[k]) begin
               if (bit_of(hs_last, k))
                  set_req(k, ($urandom_range(0, 1) == 1), rnd_word(), rnd_word(), 4'($urandom_range(0, 15)));
               else if ($urandom_range(0, 15) == 0)
                  drv_v[k] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               set_req(k, 1'b1, rnd_word(), rnd_word(), 4'($urandom_range(0, 15)));
            end
         end
         for (int k = 0; k < N; k++) r[k] = ($urandom_range(0, 3) != 0);
         i_rsp_ready = r;
         i_reset     = ($urandom_range(0, 199) == 0);
         step();
      end
      i_reset = 1'b0;
      for (int k = 0; k < N; k++) set_req(k, 1'b0, 32'h0, 32'h0, 4'h0);
      i_rsp_ready = '1;
      step();
      wait_idle();
      chk("drain_queue", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
